// File: rtl/register_readback.sv
// Parallel-to-serial readback: snapshots a WIDTH-bit value on request and
// streams it LSB-first as CHUNK-bit beats over a valid/ready handshake.
module register_readback #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic [WIDTH-1:0] in0,
    output logic             busy,
    output logic [CHUNK-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             done
);

    localparam int NBEATS = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int SNAP_W = NBEATS * CHUNK;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_reg, state_next;
    logic [SNAP_W-1:0] snapshot_reg, snapshot_next, snapshot_shifted;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              done_reg, done_next;

    // Beat-wise right shift by one CHUNK; the top beat is zero-filled.
    genvar gi;
    generate
        for (gi = 0; gi < NBEATS; gi++) begin : g_shift
            if (gi == NBEATS - 1) begin : g_top
                assign snapshot_shifted[gi*CHUNK +: CHUNK] = '0;
            end else begin : g_mid
                assign snapshot_shifted[gi*CHUNK +: CHUNK] = snapshot_reg[(gi+1)*CHUNK +: CHUNK];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            snapshot_reg <= '0;
            count_reg    <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            snapshot_reg <= snapshot_next;
            count_reg    <= count_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        snapshot_next = snapshot_reg;
        count_next    = count_reg;
        done_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    snapshot_next = SNAP_W'(in0);
                    count_next    = CNT_W'(NBEATS - 1);
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                // req is deliberately ignored here, even on the final beat.
                if (out_ready) begin
                    snapshot_next = snapshot_shifted;
                    if (count_reg == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        count_next = count_reg - CNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg == SHIFT);
    assign out_valid = busy;
    assign out_data  = busy ? snapshot_reg[CHUNK-1:0] : '0;
    assign out_last  = busy && (count_reg == '0);
    assign done      = done_reg;

endmodule

// File: tb/tb_register_readback.sv
// Bench for register_readback: three instances (32/8, 12/8, 16/16) checked
// every cycle against a beat-list model, plus literal beat-sequence checks.
module tb_register_readback;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        req [3];
    logic [31:0] in0_v [3];
    logic        rdy [3];

    logic        busy_o [3];
    logic        valid_o [3];
    logic        last_o [3];
    logic        done_o [3];
    logic [7:0]  d0, d1;
    logic [15:0] d2;

    int total = 0;
    int bad   = 0;

    register_readback #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .clock(clock), .reset(reset), .req(req[0]), .in0(in0_v[0]),
        .busy(busy_o[0]), .out_data(d0), .out_valid(valid_o[0]),
        .out_ready(rdy[0]), .out_last(last_o[0]), .done(done_o[0])
    );

    register_readback #(.WIDTH(12), .CHUNK(8)) u_dut12 (
        .clock(clock), .reset(reset), .req(req[1]), .in0(in0_v[1][11:0]),
        .busy(busy_o[1]), .out_data(d1), .out_valid(valid_o[1]),
        .out_ready(rdy[1]), .out_last(last_o[1]), .done(done_o[1])
    );

    register_readback #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clock(clock), .reset(reset), .req(req[2]), .in0(in0_v[2][15:0]),
        .busy(busy_o[2]), .out_data(d2), .out_valid(valid_o[2]),
        .out_ready(rdy[2]), .out_last(last_o[2]), .done(done_o[2])
    );

    // Model: per instance, a list of beats cut from the captured value.
    int          mw [3] = '{32, 12, 16};
    int          mc [3] = '{8, 8, 16};
    int          m_nb [3];
    bit          m_active [3];
    int          m_pos [3];
    bit          m_done [3];
    logic [31:0] m_beat [3][4];

    logic [31:0] log0[$], log1[$], log2[$];
    int          busy_cnt0 = 0;
    int          done_cnt0 = 0;

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h expected=%h at t=%0t", name, inst, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_data(input int i);
        case (i)
            0:       return {24'b0, d0};
            1:       return {24'b0, d1};
            default: return {16'b0, d2};
        endcase
    endfunction

    function automatic logic [31:0] log_at(input int i, input int k);
        case (i)
            0:       return log0[k];
            1:       return log1[k];
            default: return log2[k];
        endcase
    endfunction

    function automatic int log_size(input int i);
        case (i)
            0:       return log0.size();
            1:       return log1.size();
            default: return log2.size();
        endcase
    endfunction

    task automatic check_log(input int i, input string name, input int n,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] exp [4];
        exp = '{e0, e1, e2, e3};
        check({name, "_count"}, i, 32'(log_size(i)), 32'(n));
        for (int k = 0; k < n && k < log_size(i); k++)
            check({name, "_beat"}, i, log_at(i, k), exp[k]);
    endtask

    // Compare process: check outputs at negedge, then advance the model with
    // the inputs that the coming rising edge will sample.
    initial begin
        logic [31:0] wmask, cmask, v, exp_data;
        bit          exp_last;
        for (int i = 0; i < 3; i++) begin
            m_nb[i]     = (mw[i] + mc[i] - 1) / mc[i];
            m_active[i] = 1'b0;
            m_pos[i]    = 0;
            m_done[i]   = 1'b0;
        end
        forever begin
            @(negedge clock);
            if (busy_o[0] === 1'b1) busy_cnt0++;
            if (done_o[0] === 1'b1) done_cnt0++;
            for (int i = 0; i < 3; i++) begin
                exp_data = m_active[i] ? m_beat[i][m_pos[i]] : 32'h0;
                exp_last = m_active[i] && (m_pos[i] == m_nb[i] - 1);
                check("busy",      i, {31'b0, busy_o[i]},  {31'b0, m_active[i]});
                check("out_valid", i, {31'b0, valid_o[i]}, {31'b0, m_active[i]});
                check("out_last",  i, {31'b0, last_o[i]},  {31'b0, exp_last});
                check("done",      i, {31'b0, done_o[i]},  {31'b0, m_done[i]});
                check("out_data",  i, dut_data(i), exp_data);
                if (valid_o[i] === 1'b1 && rdy[i] && !reset) begin
                    case (i)
                        0:       log0.push_back(dut_data(i));
                        1:       log1.push_back(dut_data(i));
                        default: log2.push_back(dut_data(i));
                    endcase
                end
                if (reset) begin
                    m_active[i] = 1'b0;
                    m_pos[i]    = 0;
                    m_done[i]   = 1'b0;
                end else if (!m_active[i]) begin
                    m_done[i] = 1'b0;
                    if (req[i]) begin
                        wmask = (mw[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << mw[i]) - 32'd1);
                        cmask = (32'd1 << mc[i]) - 32'd1;
                        v     = in0_v[i] & wmask;
                        for (int k = 0; k < m_nb[i]; k++)
                            m_beat[i][k] = (v >> (k * mc[i])) & cmask;
                        m_active[i] = 1'b1;
                        m_pos[i]    = 0;
                    end
                end else begin
                    m_done[i] = rdy[i] && (m_pos[i] == m_nb[i] - 1);
                    if (rdy[i]) begin
                        m_pos[i]++;
                        if (m_pos[i] == m_nb[i]) m_active[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
        log2.delete();
        busy_cnt0 = 0;
        done_cnt0 = 0;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i]   = 1'b0;
            in0_v[i] = 32'h0;
            rdy[i]   = 1'b1;
        end
        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        // Full-throughput readback on all three instances.
        clear_logs();
        req[0] = 1'b1; in0_v[0] = 32'hA1B2C3D4;
        req[1] = 1'b1; in0_v[1] = 32'h0000_0ABC;
        req[2] = 1'b1; in0_v[2] = 32'h0000_5A5A;
        cyc();
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        @(negedge clock);
        check("first_beat_latency", 0, {24'b0, d0}, 32'h0000_00D4);
        check("single_beat_last", 2, {31'b0, last_o[2]}, 32'h1);
        repeat (7) cyc();
        check_log(0, "seq32", 4, 32'hD4, 32'hC3, 32'hB2, 32'hA1);
        check_log(1, "seq12", 2, 32'hBC, 32'h0A, 32'h0, 32'h0);
        check_log(2, "seq16", 1, 32'h5A5A, 32'h0, 32'h0, 32'h0);
        check("busy_cycles", 0, 32'(busy_cnt0), 32'd4);
        check("done_pulses", 0, 32'(done_cnt0), 32'd1);

        // Three-cycle stall on beat 2 while in0 is cleared.
        clear_logs();
        req[0] = 1'b1; in0_v[0] = 32'hA1B2C3D4;
        cyc();
        req[0] = 1'b0;
        cyc();
        rdy[0] = 1'b0; in0_v[0] = 32'h0;
        repeat (3) cyc();
        @(negedge clock);
        check("stall_hold_data", 0, {24'b0, d0}, 32'h0000_00C3);
        cyc();
        rdy[0] = 1'b1;
        repeat (6) cyc();
        check_log(0, "stall_seq", 4, 32'hD4, 32'hC3, 32'hB2, 32'hA1);
        check("stall_busy_cycles", 0, 32'(busy_cnt0), 32'd8);
        check("stall_done_pulses", 0, 32'(done_cnt0), 32'd1);

        // Reset after the first beat abandons the readback.
        clear_logs();
        req[0] = 1'b1; in0_v[0] = 32'hA1B2C3D4;
        cyc();
        req[0] = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_valid", 0, {31'b0, valid_o[0]}, 32'h0);
        check("rst_mid_busy",  0, {31'b0, busy_o[0]},  32'h0);
        check("rst_mid_done",  0, {31'b0, done_o[0]},  32'h0);
        cyc();
        clear_logs();
        req[0] = 1'b1; in0_v[0] = 32'h01020304;
        cyc();
        req[0] = 1'b0;
        repeat (6) cyc();
        check_log(0, "after_rst_seq", 4, 32'h04, 32'h03, 32'h02, 32'h01);
        check("after_rst_done_pulses", 0, 32'(done_cnt0), 32'd1);

        // req held high: back-to-back readbacks with in0 changing every cycle.
        clear_logs();
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 3; i++) begin
                req[i]   = 1'b1;
                in0_v[i] = $urandom;
            end
            cyc();
        end
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        repeat (6) cyc();
        check("held_req_done_pulses", 0, 32'(done_cnt0), 32'd4);

        // Randomized traffic with back-pressure and occasional reset.
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < 3; i++) begin
                req[i]   = ($urandom_range(0, 3) == 0);
                in0_v[i] = $urandom;
                rdy[i]   = ($urandom_range(0, 3) != 0);
            end
            reset = ($urandom_range(0, 99) == 0);
            cyc();
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0;
            rdy[i] = 1'b1;
        end
        repeat (10) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
